// File: rtl/mpf_prim_fifo_lutram_pkg.sv
// Shared helpers for the MPF LUTRAM FIFO: parameter legality and reset-time flag values.
package mpf_prim_fifo_lutram_pkg;

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  // almostFull out of reset is only 1 for a threshold that covers the whole depth.
  function automatic logic almost_full_reset(input int unsigned threshold,
                                             input int unsigned n_entries);
    return (threshold >= n_entries) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/mpf_prim_lutram_1w1r.sv
// Generic LUTRAM array: one synchronous write port, one asynchronous read port, contents not reset.
module mpf_prim_lutram_1w1r #(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned N_ENTRIES   = 16
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [$clog2(N_ENTRIES)-1:0] i_wr_addr,
  input  logic [N_DATA_BITS-1:0]       i_wr_data,
  input  logic [$clog2(N_ENTRIES)-1:0] i_rd_addr,
  output logic [N_DATA_BITS-1:0]       o_rd_data
);

  logic [N_DATA_BITS-1:0] r_mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mpf_prim_fifo_lutram.sv
// Show-ahead FIFO on LUTRAM with registered full/empty/almost-full flags.
// Define MPF_FIFO_ASSERT_EN to compile in simulation-only protocol and parameter checks.
module mpf_prim_fifo_lutram
  import mpf_prim_fifo_lutram_pkg::*;
#(
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned N_ENTRIES   = 16,
  parameter int unsigned THRESHOLD   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   notFull,
  output logic                   almostFull,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   notEmpty
);

  localparam int unsigned PTR_W = $clog2(N_ENTRIES);
  localparam logic        AF_RESET = almost_full_reset(THRESHOLD, N_ENTRIES);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(N_ENTRIES);
  localparam cnt_t CNT_AF   = cnt_t'(N_ENTRIES - THRESHOLD);

  ptr_t r_wr_ptr;
  ptr_t r_rd_ptr;
  cnt_t r_count;
  logic r_not_empty;
  logic r_not_full;
  logic r_almost_full;
  cnt_t w_count_next;

  assign w_count_next = r_count + cnt_t'(enq_en) - cnt_t'(deq_en);

  // Flags are registered from count_next so they reflect this edge's enq/deq
  // without any combinational path from the handshake inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_not_empty   <= 1'b0;
      r_not_full    <= 1'b1;
      r_almost_full <= AF_RESET;
    end else begin
      if (enq_en) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      if (deq_en) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      r_count       <= w_count_next;
      r_not_empty   <= (w_count_next != '0);
      r_not_full    <= (w_count_next != CNT_FULL);
      r_almost_full <= (w_count_next >= CNT_AF);
    end
  end

  mpf_prim_lutram_1w1r #(
    .N_DATA_BITS (N_DATA_BITS),
    .N_ENTRIES   (N_ENTRIES)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (enq_en & ~reset),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (enq_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (first)
  );

  assign notEmpty   = r_not_empty;
  assign notFull    = r_not_full;
  assign almostFull = r_almost_full;

`ifdef MPF_FIFO_ASSERT_EN
  initial begin
    if (!is_pow2(N_ENTRIES) || N_ENTRIES < 2)
      $fatal(1, "mpf_prim_fifo_lutram: N_ENTRIES=%0d is not a power of two >= 2", N_ENTRIES);
    if (THRESHOLD >= N_ENTRIES)
      $fatal(1, "mpf_prim_fifo_lutram: THRESHOLD=%0d must be below N_ENTRIES=%0d",
             THRESHOLD, N_ENTRIES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (enq_en && !r_not_full)
        $fatal(1, "mpf_prim_fifo_lutram: enq_en while full");
      if (deq_en && !r_not_empty)
        $fatal(1, "mpf_prim_fifo_lutram: deq_en while empty");
    end
  end
`else
  // Unchecked build: illegal enq/deq silently corrupt the pointers.
`endif

endmodule

// File: tb/tb_mpf_prim_fifo_lutram.sv
// Directed + randomized scoreboard bench for mpf_prim_fifo_lutram (16 x 16, THRESHOLD=3).
module tb_mpf_prim_fifo_lutram;

  localparam int unsigned DW  = 16;
  localparam int unsigned NE  = 16;
  localparam int unsigned THR = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] enq_data;
  logic          enq_en;
  logic          notFull;
  logic          almostFull;
  logic [DW-1:0] first;
  logic          deq_en;
  logic          notEmpty;

  int unsigned   vectors = 0;
  int unsigned   miscompares = 0;

  logic [DW-1:0] sb[$];
  int unsigned   ref_cnt = 0;

  always #5 clk = ~clk;

  mpf_prim_fifo_lutram #(
    .N_DATA_BITS (DW),
    .N_ENTRIES   (NE),
    .THRESHOLD   (THR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enq_data   (enq_data),
    .enq_en     (enq_en),
    .notFull    (notFull),
    .almostFull (almostFull),
    .first      (first),
    .deq_en     (deq_en),
    .notEmpty   (notEmpty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare registered outputs (settled since the last edge) against the reference model.
  task automatic check_state();
    chk("notEmpty",   {31'd0, notEmpty},   {31'd0, ref_cnt != 0});
    chk("notFull",    {31'd0, notFull},    {31'd0, ref_cnt != NE});
    chk("almostFull", {31'd0, almostFull}, {31'd0, ref_cnt >= NE - THR});
    if (ref_cnt != 0) chk("first", {16'd0, first}, {16'd0, sb[0]});
  endtask

  task automatic cyc(input logic e, input logic [DW-1:0] d, input logic q);
    check_state();
    enq_en = e; enq_data = d; deq_en = q;
    @(posedge clk);
    if (q) void'(sb.pop_front());
    if (e) sb.push_back(d);
    ref_cnt = ref_cnt + int'(e) - int'(q);
    #1;
    enq_en = 1'b0; deq_en = 1'b0;
  endtask

  task automatic do_reset(input logic with_enq);
    reset = 1'b1; enq_en = with_enq; enq_data = 16'hDEAD; deq_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0; enq_en = 1'b0;
    sb.delete();
    ref_cnt = 0;
  endtask

  initial begin
    int unsigned sent;
    int unsigned got;
    int unsigned budget;
    logic e, q;

    reset = 1'b1; enq_en = 1'b0; deq_en = 1'b0; enq_data = '0;
    do_reset(1'b0);

    // Reset state held for 5 idle cycles
    repeat (5) cyc(1'b0, '0, 1'b0);

    // Single entry: visible next cycle, then popped
    cyc(1'b1, 16'hA5A5, 1'b0);
    chk("single_first", {16'd0, first}, 32'h0000A5A5);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Fill to 12, 13, 16 checking each threshold
    for (int i = 0; i < 12; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0);
    chk("af_at_12", {31'd0, almostFull}, 32'd0);
    cyc(1'b1, 16'h100C, 1'b0);
    chk("af_at_13", {31'd0, almostFull}, 32'd1);
    for (int i = 13; i < 16; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0);
    chk("full_at_16", {31'd0, notFull}, 32'd0);
    cyc(1'b0, '0, 1'b0);

    // Drain: one deq leaves full, then down to 12
    cyc(1'b0, '0, 1'b1);
    chk("nf_at_15", {31'd0, notFull}, 32'd1);
    chk("af_at_15", {31'd0, almostFull}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    chk("af_drain_12", {31'd0, almostFull}, 32'd0);
    while (ref_cnt > 0) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Steady state: one entry, simultaneous enq+deq for 20 cycles
    cyc(1'b1, 16'h2000, 1'b0);
    for (int i = 1; i <= 20; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Reset mid-operation with an enqueue sampled alongside it
    cyc(1'b1, 16'h3333, 1'b0);
    do_reset(1'b1);
    cyc(1'b0, '0, 1'b0);
    chk("reset_empty", {31'd0, notEmpty}, 32'd0);

    // Wrap-around: random legal traffic of values 0..99
    sent = 0; got = 0; budget = 0;
    while ((sent < 100 || ref_cnt > 0) && budget < 3000) begin
      e = (sent < 100) && (ref_cnt < NE) && ($urandom_range(0, 99) < 60);
      q = (ref_cnt > 0) && ($urandom_range(0, 99) < 50);
      if (q) begin
        chk("wrap_order", {16'd0, first}, got);
        got++;
      end
      cyc(e, 16'(sent), q);
      if (e) sent++;
      budget++;
    end
    chk("wrap_count", got, 32'd100);
    cyc(1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mpf_prim_fifo_lutram.md
# mpf_prim_fifo_lutram

Parameterized show-ahead FIFO with LUTRAM storage, a programmable almost-full threshold, and a full/empty handshake. It is the general-purpose buffering primitive of the MPF shim library. Clients use it where many entries are needed and the producer needs early back-pressure. An example is tracking in-flight requests that may loop back into the same FIFO on a retry.

## Interface
- N_DATA_BITS, default 32: width of each entry.
- N_ENTRIES, default 16: depth; power of two, at least 2.
- THRESHOLD, default 1: almostFull asserts when free slots are at most THRESHOLD; range 0 to N_ENTRIES-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- enq_data  in  N_DATA_BITS  data to write.
- enq_en  in  1  write enq_data this cycle; legal only while notFull=1.
- notFull  out  1  at least one free slot.
- almostFull  out  1  free slots are at most THRESHOLD.
- first  out  N_DATA_BITS  oldest entry; valid only while notEmpty=1.
- deq_en  in  1  pop the oldest entry; legal only while notEmpty=1.
- notEmpty  out  1  at least one entry stored.

## Operation
- Storage is an N_ENTRIES x N_DATA_BITS LUTRAM with 1 synchronous write port and 1 asynchronous read port.
- Write and read pointers are log2(N_ENTRIES) bits wide. They wrap naturally from N_ENTRIES-1 to 0.
- Occupancy counter is log2(N_ENTRIES)+1 bits wide.
- Each cycle: count_next = count + enq_en - deq_en.
- enq_en and deq_en in the same cycle: count is unchanged and both pointers advance.
- The registered flags are computed from count_next:
  - notEmpty = (count_next != 0).
  - notFull = (count_next != N_ENTRIES).
  - almostFull = (count_next >= N_ENTRIES - THRESHOLD).
- first is the asynchronous read at the read pointer. It is the show-ahead head of the FIFO.
- Illegal cases are unchecked in synthesis:
  - enq_en while notFull=0 is illegal, even when deq_en is asserted in the same cycle.
  - deq_en while notEmpty=0 is illegal.
- Storage contents are not reset.

## Timing
- Reset values: count=0, pointers=0, notEmpty=0, notFull=1, almostFull=(THRESHOLD >= N_ENTRIES ? 1 : 0) (0 for legal parameters).
- first is don't-care after reset and whenever notEmpty=0.
- Enqueue latency: data written at edge T appears on first, with notEmpty=1, in cycle T+1 when the FIFO was empty.
- Dequeue: after deq_en at edge T, the next entry appears on first in cycle T+1, or notEmpty drops at T+1.
- All flags are registered and reflect every enq/deq sampled at the preceding edge; there is no combinational path from enq_en/deq_en to any output.
- first depends combinationally on the read pointer and the storage contents only.
- Reset during operation: the FIFO is empty in the next cycle. Any enq_en sampled together with reset is discarded.

## Configuration
- MPF_FIFO_ASSERT_EN defined: simulation-only checks are compiled in.
  - $fatal on enq_en while notFull=0.
  - $fatal on deq_en while notEmpty=0.
  - $fatal at elaboration if N_ENTRIES is not a power of two, or THRESHOLD >= N_ENTRIES.
  - Checks are suppressed while reset=1.
- MPF_FIFO_ASSERT_EN undefined: no checks; illegal operations corrupt pointers silently.

## Structure
- No shared-package content is needed; pointer and count typedefs are local to the module.
- One sub-module is natural: mpf_prim_lutram_1w1r, a generic LUTRAM array (write enable, write address, write data, asynchronous read address/data).
- The FIFO module holds the pointers, counter and flag registers.

## Test plan
All scenarios use N_DATA_BITS=16, N_ENTRIES=16, THRESHOLD=3.
- Reset: after reset -> notEmpty=0, notFull=1, almostFull=0, for 5 idle cycles.
- Single entry: enq 0xA5A5 at edge T -> at T+1 notEmpty=1 and first=0xA5A5; deq at T+1 -> notEmpty=0 at T+2.
- Thresholds: enq 12 entries -> almostFull=0; 13th -> almostFull=1; 16th -> notFull=0.
- Drain from full: one deq -> notFull=1 and almostFull=1 next cycle. Deq down to 12 entries -> almostFull=0.
- Steady state: with 1 entry, simultaneous enq+deq for 20 cycles -> notEmpty stays 1, notFull stays 1, and first shows values in insertion order.
- Wrap-around: random enq/deq (never illegal) of 100 values 0..99 -> first yields 0..99 in order, and flags match a reference count every cycle.
